// File: rtl/mux_pkg.sv
// mux_pkg: shared constants for the 2:1 packet arbiter.
//   state_t        : arbiter FSM state (IDLE / SEL0 / SEL1)
//   SEL_IN0/SEL_IN1: encoding of the downstream mux select (s0)
package mux_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t SEL0 = 2'd1;
  localparam state_t SEL1 = 2'd2;

  localparam logic SEL_IN0 = 1'b0;
  localparam logic SEL_IN1 = 1'b1;

endpackage

// File: rtl/mux_out_reg.sv
// mux_out_reg: single-entry valid/ready output register.
//   clk, rst    : clock, async active-high reset
//   i_load      : upstream beat accepted this cycle, capture i_data
//   i_data[W]   : beat payload ({last, data} in the arbiter)
//   i_ready     : downstream ready
//   o_valid     : register holds a beat
//   o_data[W]   : held beat, stable while o_valid & !i_ready
//   o_can_load  : register may accept a beat this cycle
module mux_out_reg #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_can_load
);

  logic         r_valid;
  logic [W-1:0] r_data;

  // Empty, or being drained this cycle: allows back-to-back beats.
  assign o_can_load = ~r_valid | i_ready;
  assign o_valid    = r_valid;
  assign o_data     = r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mux_2to1_arb.sv
// mux_2to1_arb: packet-locked round-robin arbiter for two valid/ready
// sources feeding one registered output.
//   clk, rst                    : clock, async active-high reset
//   in{0,1}_valid/data/last     : source beats
//   in{0,1}_ready               : source beat accepted when valid & ready
//   s0                          : downstream mux select (0 = in0, 1 = in1)
//   out_valid/data/last         : registered output beat
//   out_ready                   : downstream accepts beat
//   pkt_cnt0/pkt_cnt1 (CNT_W)   : saturating per-source packet counters,
//                                 present only with MUX_ARB_STATS_EN defined
module mux_2to1_arb
  import mux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in0_valid,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_last,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_last,
  output logic              in1_ready,
  output logic              s0,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready
`ifdef MUX_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1
`endif
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_last_grant;
  logic              w_can_load;
  logic              w_acc;
  logic              w_acc_last;
  logic              w_sel_last;
  logic [DATA_W-1:0] w_sel_data;
  logic [DATA_W:0]   w_out;

  assign s0        = (r_state == SEL1) ? SEL_IN1 : SEL_IN0;
  assign in0_ready = (r_state == SEL0) & w_can_load;
  assign in1_ready = (r_state == SEL1) & w_can_load;

  // In IDLE s0 is 0 but neither ready is high, so nothing is accepted.
  assign w_sel_data = (s0 == SEL_IN1) ? in1_data : in0_data;
  assign w_sel_last = (s0 == SEL_IN1) ? in1_last : in0_last;
  assign w_acc      = (in0_valid & in0_ready) | (in1_valid & in1_ready);
  assign w_acc_last = w_acc & w_sel_last;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        // Contention goes to whichever source did not finish last.
        if (in0_valid & in1_valid)
          w_state_nxt = (r_last_grant == SEL_IN1) ? SEL0 : SEL1;
        else if (in0_valid)
          w_state_nxt = SEL0;
        else if (in1_valid)
          w_state_nxt = SEL1;
      end
      // Grant stays locked, even across valid gaps, until the last beat.
      SEL0, SEL1: if (w_acc_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= SEL_IN1;
    end else begin
      r_state <= w_state_nxt;
      if (w_acc_last) r_last_grant <= s0;
    end
  end

  mux_out_reg #(
    .W (DATA_W + 1)
  ) u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_acc),
    .i_data     ({w_sel_last, w_sel_data}),
    .i_ready    (out_ready),
    .o_valid    (out_valid),
    .o_data     (w_out),
    .o_can_load (w_can_load)
  );

  assign out_last = w_out[DATA_W];
  assign out_data = w_out[DATA_W-1:0];

`ifdef MUX_ARB_STATS_EN
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  // Count completed packets per source, holding at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (w_acc_last) begin
      if (s0 == SEL_IN0 && !(&r_cnt0)) r_cnt0 <= r_cnt0 + CNT_W'(1);
      if (s0 == SEL_IN1 && !(&r_cnt1)) r_cnt1 <= r_cnt1 + CNT_W'(1);
    end
  end

  assign pkt_cnt0 = r_cnt0;
  assign pkt_cnt1 = r_cnt1;
`else
  // CNT_W only sizes the counters; keep it referenced when they are absent.
  if (CNT_W > 0) begin : g_cnt_w_ref
  end
`endif

endmodule

// File: doc/mux_2to1_arb.md
MUX_2TO1_ARB -- requirements
Module: mux_2to1_arb

Interface
REQ-001 Parameter DATA_W, default 8, width of each data path.
REQ-002 Parameter CNT_W, default 16, width of the statistics counters (used only when MUX_ARB_STATS_EN is defined).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in0_valid  input  1  source 0 beat valid.
REQ-006 in0_data  input  DATA_W  source 0 data.
REQ-007 in0_last  input  1  source 0 final beat of packet.
REQ-008 in0_ready  output  1  source 0 beat accepted when valid&ready.
REQ-009 in1_valid / in1_data / in1_last / in1_ready: same as in0_*, for source 1.
REQ-010 s0  output  1  select for the downstream 2:1 mux; 0 = in0, 1 = in1.
REQ-011 out_valid  output  1  registered output beat valid.
REQ-012 out_data  output  DATA_W  registered output data.
REQ-013 out_last  output  1  registered output last flag.
REQ-014 out_ready  input  1  downstream accepts the beat when out_valid&out_ready.

Function
REQ-015 FSM states: IDLE, SEL0, SEL1; s0 = 1 only in SEL1.
REQ-016 IDLE, one valid: go to SEL<n> of that source next cycle.
REQ-017 IDLE, both valid: go to the source not granted last (round-robin); last_grant resets to 1, so in0 wins first.
REQ-018 IDLE, neither valid: stay; both ready = 0.
REQ-019 SELn: inn_ready = !out_valid | out_ready; other source ready = 0.
REQ-020 An accepted beat loads out_data/out_last and sets out_valid on the next edge (1-cycle latency).
REQ-021 out_valid clears on out_ready with no new beat; out_* hold stable while out_valid & !out_ready.
REQ-022 In SELn, an accepted beat with inn_last=1 -> IDLE next cycle and last_grant <= n; grant is locked otherwise.
REQ-023 One idle bubble cycle between packets is required.
REQ-024 inn_valid deassertion mid-packet keeps the grant; no timeout.
REQ-025 Full throughput within a packet: one beat per cycle while out_ready = 1.

Reset
REQ-026 rst=1 immediately forces state IDLE, s0=0, out_valid=0, out_last=0, out_data=0, last_grant=1, both ready=0.
REQ-027 Reset mid-packet discards the partial packet and the held output beat; no beat is emitted.

Configuration
REQ-028 With MUX_ARB_STATS_EN defined: outputs pkt_cnt0 and pkt_cnt1 (CNT_W) count accepted last beats per source.
REQ-029 The counters saturate at all-ones, reset to 0, and increment on the same edge the last beat is accepted.
REQ-030 Without MUX_ARB_STATS_EN: the counter ports and logic are absent; all other behaviour is identical.

Structure
REQ-031 Shared package mux_pkg holds the state enum (IDLE/SEL0/SEL1) and the select encoding constants SEL_IN0=0, SEL_IN1=1.
REQ-032 Output register is sub-module mux_out_reg (DATA_W+1 bits, valid/ready); arbiter FSM stays in the top.

Verification
REQ-033 Reset release, in0_valid=1 with data 8'hA5 and last=1, out_ready=1: s0=0; out_data=8'hA5 and out_last=1 two cycles after valid; state returns to IDLE.
REQ-034 Both sources valid with 3-beat packets (in0 11,12,13; in1 21,22,23): output order 11,12,13,21,22,23; s0 = 0 then 1; one bubble between packets.
REQ-035 out_ready low for 4 cycles mid-packet: out_data holds; inn_ready=0; no beat lost or duplicated.
REQ-036 in1 packet in progress while in0 asserts valid: in0_ready stays 0 until in1 last is accepted; in0 is then granted.
REQ-037 rst pulse during beat 2 of 3: out_valid=0 and s0=0 immediately; next grant goes to in0.
REQ-038 MUX_ARB_STATS_EN defined, 5 packets on in1 with CNT_W=2: pkt_cnt1 saturates at 3 and pkt_cnt0 = 0.
